// File: rtl/uart_tx_io_if.sv
// Shared dread/dwrite I/O port bundle between the CPU data-bus decode and an I/O peripheral.
interface uart_tx_io_if;
  logic [15:0] dread_addr;
  logic [15:0] dread_data;
  logic [15:0] dwrite_addr;
  logic [15:0] dwrite_data;
  logic [1:0]  dwrite_en;

  modport master (output dread_addr, dwrite_addr, dwrite_data, dwrite_en, input dread_data);
  modport slave  (input dread_addr, dwrite_addr, dwrite_data, dwrite_en, output dread_data);
endinterface

// File: rtl/uart_tx_io.sv
// Memory-mapped 8N1 UART transmitter with a small TX FIFO and done/overflow interrupt.
// Define UART_TX_PARITY_EN to add the ctrl.pe bit and an even-parity bit per frame.
module uart_tx_io #(
  parameter logic [15:0] BASEADDR    = 16'h0010,
  parameter logic [15:0] DEFAULT_DIV = 16'd103,
  parameter int          FIFO_DEPTH  = 4
) (
  input  logic         clk,
  input  logic         reset,
  uart_tx_io_if.slave  bus,
  output logic         txd,
  output logic         interrupt
);
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t       state;
  logic [7:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]  count;
  logic [15:0]  div, cnt;
  logic [7:0]   shreg;
  logic [2:0]   bit_idx, bit_nxt;
  logic         en, ie, done, ovf, pe;
  logic         empty, full, busy, push, push_ok, pop, done_set;
  logic         wsel, rsel, ctrl_wr, div_wr;
  logic [1:0]   woff, roff;
  logic         unused;

  assign wsel    = bus.dwrite_addr[15:3] == BASEADDR[15:3];
  assign rsel    = bus.dread_addr[15:3] == BASEADDR[15:3];
  assign woff    = bus.dwrite_addr[2:1];
  assign roff    = bus.dread_addr[2:1];
  assign unused  = bus.dread_addr[0] ^ bus.dwrite_addr[0];

  assign empty   = count == '0;
  assign full    = count == (AW+1)'(FIFO_DEPTH);
  assign busy    = state != IDLE;
  assign push    = wsel && woff == 2'd0 && bus.dwrite_en[0];
  assign ctrl_wr = wsel && woff == 2'd1 && bus.dwrite_en[0];
  assign div_wr  = wsel && woff == 2'd2;
  // The FSM pops either from IDLE or straight out of the last STOP cycle (back-to-back frames).
  assign pop     = en && !empty && (state == IDLE || (state == STOP && cnt == '0));
  assign push_ok = push && (!full || pop);
  assign done_set = state == STOP && cnt == '0 && empty;
  assign bit_nxt = bit_idx + 3'd1;
  assign interrupt = ie & (done | ovf);

`ifndef UART_TX_PARITY_EN
  assign pe = 1'b0;
`endif

  always_ff @(posedge clk)
    if (push_ok) mem[wr_ptr] <= bus.dwrite_data[7:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      div    <= DEFAULT_DIV;
      en     <= 1'b0;
      ie     <= 1'b0;
      done   <= 1'b0;
      ovf    <= 1'b0;
`ifdef UART_TX_PARITY_EN
      pe     <= 1'b0;
`endif
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      if (push_ok && !pop)      count <= count + 1'b1;
      else if (!push_ok && pop) count <= count - 1'b1;

      if (push && !push_ok)                          ovf <= 1'b1;
      else if (ctrl_wr && bus.dwrite_data[7])        ovf <= 1'b0;
      if (done_set)                                  done <= 1'b1;
      else if (ctrl_wr && bus.dwrite_data[6])        done <= 1'b0;

      if (ctrl_wr) begin
        en <= bus.dwrite_data[0];
        ie <= bus.dwrite_data[1];
`ifdef UART_TX_PARITY_EN
        pe <= bus.dwrite_data[2];
`endif
      end
      if (div_wr && bus.dwrite_en[0]) div[7:0]  <= bus.dwrite_data[7:0];
      if (div_wr && bus.dwrite_en[1]) div[15:8] <= bus.dwrite_data[15:8];
    end
  end

  // Each state/bit lasts div+1 cycles; cnt reloads from div at every boundary.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      txd     <= 1'b1;
      cnt     <= '0;
      shreg   <= '0;
      bit_idx <= '0;
    end else begin
      case (state)
        IDLE: begin
          txd <= 1'b1;
          if (pop) begin
            state <= START;
            txd   <= 1'b0;
            shreg <= mem[rd_ptr];
            cnt   <= div;
          end
        end
        START:
          if (cnt == '0) begin
            state   <= DATA;
            txd     <= shreg[0];
            bit_idx <= '0;
            cnt     <= div;
          end else cnt <= cnt - 1'b1;
        DATA:
          if (cnt == '0) begin
            cnt <= div;
            if (bit_idx == 3'd7) begin
              if (pe) begin
                state <= PARITY;
                txd   <= ^shreg;
              end else begin
                state <= STOP;
                txd   <= 1'b1;
              end
            end else begin
              bit_idx <= bit_nxt;
              txd     <= shreg[bit_nxt];
            end
          end else cnt <= cnt - 1'b1;
        PARITY:
          if (cnt == '0) begin
            state <= STOP;
            txd   <= 1'b1;
            cnt   <= div;
          end else cnt <= cnt - 1'b1;
        STOP:
          if (cnt == '0) begin
            cnt <= div;
            if (pop) begin
              state <= START;
              txd   <= 1'b0;
              shreg <= mem[rd_ptr];
            end else begin
              state <= IDLE;
              txd   <= 1'b1;
            end
          end else cnt <= cnt - 1'b1;
        default: begin
          state <= IDLE;
          txd   <= 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) bus.dread_data <= '0;
    else if (rsel)
      case (roff)
        2'd1:    bus.dread_data <= {8'h00, ovf, done, busy, empty, full, pe, ie, en};
        2'd2:    bus.dread_data <= div;
        default: bus.dread_data <= '0;
      endcase
    else bus.dread_data <= '0;
  end
endmodule

// File: tb/tb_uart_tx_io.sv
// Self-checking bench for uart_tx_io: register map, randomized FIFO/frame traffic, reset and parity.
module tb_uart_tx_io;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic txd, interrupt;

  uart_tx_io_if bus();
  uart_tx_io dut (.clk(clk), .reset(reset), .bus(bus), .txd(txd), .interrupt(interrupt));

  always #5 clk = ~clk;

  localparam logic [15:0] BASE = 16'h0010;
  int n_checks = 0;
  int n_fail = 0;
  byte unsigned exp_q[$];
  bit m_ovf, m_pe;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] status(bit ovf, bit done, bit busy, bit empty, bit full,
                                         bit pe, bit ie, bit en);
    return {8'h00, ovf, done, busy, empty, full, pe, ie, en};
  endfunction

  task automatic wr(input logic [15:0] a, input logic [15:0] d, input logic [1:0] e);
    bus.dwrite_addr = a; bus.dwrite_data = d; bus.dwrite_en = e;
    @(negedge clk);
    bus.dwrite_en = 2'b00;
  endtask

  task automatic rd_check(input string tag, input logic [15:0] a, input logic [15:0] exp);
    bus.dread_addr = a;
    @(negedge clk);
    check(tag, bus.dread_data, exp);
  endtask

  task automatic count_lows(input int cycles, output int lows);
    lows = 0;
    for (int i = 0; i < cycles; i++) begin
      if (txd !== 1'b1) lows++;
      @(negedge clk);
    end
  endtask

  // Builds the ideal line waveform of every queued byte and compares it frame by frame.
  task automatic check_tx(input int div, input bit pe, input string tag);
    int t, nb, len, lows;
    logic [255:0] obs, exp;
    byte unsigned b;
    bit bits[11];
    t = 0;
    while (txd !== 1'b0 && t < 400) begin @(negedge clk); t++; end
    check({tag, "_start_seen"}, t < 400, 1'b1);
    if (t >= 400) begin exp_q.delete(); return; end
    nb = pe ? 11 : 10;
    while (exp_q.size() > 0) begin
      b = exp_q.pop_front();
      bits[0] = 1'b0;
      for (int k = 0; k < 8; k++) bits[k+1] = b[k];
      if (pe) bits[9] = ^b;
      bits[nb-1] = 1'b1;
      obs = '0; exp = '0;
      for (int j = 0; j < nb; j++)
        for (int c = 0; c <= div; c++) exp[j*(div+1)+c] = bits[j];
      len = nb * (div + 1);
      for (int i = 0; i < len; i++) begin obs[i] = txd; @(negedge clk); end
      check($sformatf("%s_frame_%02h", tag, b), obs, exp);
    end
    count_lows(3, lows);
    check({tag, "_idle_after"}, lows, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int div, n, lows, t;
    byte unsigned b;
    bus.dread_addr = '0; bus.dwrite_addr = '0; bus.dwrite_data = '0; bus.dwrite_en = '0;
    repeat (3) @(negedge clk);
    check("rst_dread", bus.dread_data, 16'h0000);
    check("rst_txd", txd, 1'b1);
    check("rst_irq", interrupt, 1'b0);
    reset = 1'b0;
    rd_check("rst_status", BASE + 16'd2, 16'h0010);
    rd_check("rst_div", BASE + 16'd4, 16'd103);
    rd_check("rd_data_reg", BASE, 16'h0000);
    rd_check("rd_off3", BASE + 16'd6, 16'h0000);
    rd_check("rd_unselected", 16'h0022, 16'h0000);
    rd_check("rd_addr0_ignored", BASE + 16'd3, 16'h0010);

    // Directed 0xA5 frame at DIV=3
    wr(BASE + 16'd4, 16'h0003, 2'b11);
    wr(BASE + 16'd2, 16'h0003, 2'b01);
    exp_q.push_back(8'hA5);
    wr(BASE, 16'hFFA5, 2'b01);
    check_tx(3, 1'b0, "a5");
    rd_check("a5_status_done", BASE + 16'd2, status(0, 1, 0, 1, 0, 0, 1, 1));
    check("a5_irq_set", interrupt, 1'b1);
    wr(BASE + 16'd2, 16'h0043, 2'b01);
    check("a5_irq_cleared", interrupt, 1'b0);
    rd_check("a5_status_w1c", BASE + 16'd2, 16'h0013);

    // Randomized bursts queued with en=0, then released
    for (int r = 0; r < 4; r++) begin
      div = $urandom_range(0, 5);
      wr(BASE + 16'd4, 16'(div), 2'b11);
      wr(BASE + 16'd2, 16'h0002, 2'b01);
      n = (r == 0) ? 5 : $urandom_range(1, 6);
      m_ovf = 1'b0;
      for (int i = 0; i < n; i++) begin
        b = 8'($urandom);
        if (exp_q.size() < 4) exp_q.push_back(b);
        else m_ovf = 1'b1;
        wr(BASE, {8'($urandom), b}, 2'b01);
      end
      rd_check($sformatf("rnd%0d_status_queued", r), BASE + 16'd2,
               status(m_ovf, 0, 0, 0, exp_q.size() == 4, 0, 1, 0));
      check($sformatf("rnd%0d_irq_ovf", r), interrupt, m_ovf);
      wr(BASE + 16'd2, 16'h0003, 2'b01);
      check_tx(div, 1'b0, $sformatf("rnd%0d", r));
      rd_check($sformatf("rnd%0d_status_done", r), BASE + 16'd2,
               status(m_ovf, 1, 0, 1, 0, 0, 1, 1));
      check($sformatf("rnd%0d_irq_done", r), interrupt, 1'b1);
      wr(BASE + 16'd2, 16'h00C3, 2'b01);
      rd_check($sformatf("rnd%0d_status_clr", r), BASE + 16'd2, 16'h0013);
      check($sformatf("rnd%0d_irq_clr", r), interrupt, 1'b0);
    end

    // Divisor byte enables
    wr(BASE + 16'd4, 16'h0003, 2'b11);
    wr(BASE + 16'd4, 16'h1200, 2'b10);
    rd_check("div_high_only", BASE + 16'd4, 16'h1203);
    wr(BASE + 16'd4, 16'hFFAB, 2'b01);
    rd_check("div_low_only", BASE + 16'd4, 16'h12AB);

    // Reset in the middle of DATA bit 3
    wr(BASE + 16'd4, 16'h0003, 2'b11);
    wr(BASE + 16'd2, 16'h0001, 2'b01);
    wr(BASE, 16'h00A5, 2'b01);
    wr(BASE, 16'h003C, 2'b01);
    wr(BASE, 16'h0077, 2'b01);
    t = 0;
    while (txd !== 1'b0 && t < 400) begin @(negedge clk); t++; end
    check("mid_start_seen", t < 400, 1'b1);
    repeat (17) @(negedge clk);
    check("mid_bit3_low", txd, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_txd", txd, 1'b1);
    check("mid_rst_irq", interrupt, 1'b0);
    reset = 1'b0;
    rd_check("mid_rst_status", BASE + 16'd2, 16'h0010);
    rd_check("mid_rst_div", BASE + 16'd4, 16'd103);
    count_lows(40, lows);
    check("mid_no_frames", lows, 0);
    wr(BASE + 16'd2, 16'h0001, 2'b01);
    count_lows(40, lows);
    check("mid_fifo_flushed", lows, 0);
    rd_check("mid_status_en", BASE + 16'd2, 16'h0011);

    // Parity frame (pe only sticks when the parity build is enabled)
`ifdef UART_TX_PARITY_EN
    m_pe = 1'b1;
`else
    m_pe = 1'b0;
`endif
    wr(BASE + 16'd4, 16'h0002, 2'b11);
    wr(BASE + 16'd2, 16'h0007, 2'b01);
    rd_check("par_ctrl", BASE + 16'd2, status(0, 0, 0, 1, 0, m_pe, 1, 1));
    exp_q.push_back(8'h07);
    wr(BASE, 16'h0007, 2'b01);
    check_tx(2, m_pe, "par");
    rd_check("par_status_done", BASE + 16'd2, status(0, 1, 0, 1, 0, m_pe, 1, 1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_tx_io.md
Name: uart_tx_io

Overview:
Memory-mapped UART transmitter peripheral that sits on the I/O side of the system data-bus decode, below MEMADDRBASE. It consumes the decoded I/O write strobes and produces registered read data on the shared dread/dwrite port protocol. Bytes written by the CPU are queued in a small FIFO and serialised on txd as 8N1 frames. A completion flag can raise the interrupt line.

Parameters:
BASEADDR, 16'h0010, byte address of register window; must be 8-byte aligned and < MEMADDRBASE
DEFAULT_DIV, 16'd103, reset value of divisor register; each bit lasts DIV+1 clk cycles
FIFO_DEPTH, 4, TX FIFO entries; power of two, 2..16

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high; clears all state
dread_addr  input  16  read byte address from CPU
dread_data  output  16  read data, valid one cycle after dread_addr
dwrite_addr  input  16  write byte address
dwrite_data  input  16  write data; [7:0] low byte, [15:8] high byte
dwrite_en  input  2  byte write enables, already gated to I/O range; [0] low, [1] high
txd  output  1  serial output, idle high
interrupt  output  1  level interrupt request

Behaviour:
- Clock is clk; reset is synchronous active-high. Reset values: dread_data=0, txd=1, interrupt=0, FIFO empty, divisor=DEFAULT_DIV, ctrl=0, all sticky flags=0.
- Select: addr[15:3]==BASEADDR[15:3]; offset = addr[2:1] (word registers, addr[0] ignored).
- Offset 0 DATA: write with dwrite_en[0] pushes dwrite_data[7:0]; high byte ignored. Read returns 0.
- Offset 1 STATUS/CTRL: read {8'h0, ovf, done, busy, empty, full, 1'b0, ie, en} in bits [7:0] with ie=bit1, en=bit0, full=bit3, empty=bit4, busy=bit5, done=bit6, ovf=bit7. Write with dwrite_en[0]: bits[1:0] load en/ie; writing 1 to bit6 clears done, 1 to bit7 clears ovf (W1C). Writing 0 to either leaves it unchanged.
- Offset 2 DIV: 16-bit divisor; dwrite_en[0]/[1] update the low/high byte independently.
- Offset 3 and unselected reads return 16'h0000. Reads have no side effects.
- Read latency: dread_data registered; the value for dread_addr at edge N is presented after edge N and held until edge N+1.
- Push while FIFO full: byte dropped, ovf set, FIFO unchanged.
- TX FSM: IDLE -> START -> DATA(8 bits, LSB first) -> STOP -> IDLE. Each state or bit lasts DIV+1 cycles. The bit counter reloads from the divisor register at each bit boundary, so a divisor write mid-frame takes effect at the next bit.
- IDLE pops the FIFO head and enters START in the cycle after (en==1 && !empty); txd=1 while in IDLE.
- busy=1 in any state other than IDLE.
- On leaving STOP with the FIFO empty, done is set. If the FIFO is not empty and en==1, the FSM goes directly to START of the next byte with no idle gap.
- Clearing en mid-frame completes the current frame; no further pops.
- A push and a pop in the same cycle are both honoured (count unchanged), including when the FIFO is full.
- interrupt = ie & (done | ovf); combinationally derived from registered flags.
- A set and a W1C clear of done in the same cycle: set wins.
- Reset mid-frame: txd=1 on the next cycle, frame abandoned, FIFO emptied.

Optional Feature:
UART_TX_PARITY_EN: when defined, ctrl bit2 (pe) is R/W. With pe=1 an even-parity bit is sent between DATA and STOP, making frames 11 bits. When undefined, bit2 reads 0, writes are ignored, and frames are always 10 bits.

Test Plan:
- Reset then read BASEADDR+2 -> dread_data=16'h0010 next cycle (empty=1, en=0, ie=0); read BASEADDR+4 -> 16'd103.
- DIV=3, ctrl=3, push 8'hA5 -> txd low 4 cycles, then bits 1,0,1,0,0,1,0,1, then high 4 cycles; done=1 and interrupt=1; W1C 0x40 -> interrupt=0.
- en=0, push 5 bytes with FIFO_DEPTH=4 -> full=1, ovf=1, interrupt high if ie=1; en=1 -> exactly 4 frames, back-to-back, no idle gap.
- Write DIV high byte only with dwrite_en=2'b10, data 16'h1200 -> DIV=16'h1203 (low byte preserved).
- Assert reset mid DATA bit 3 -> txd=1 next cycle, status reads 16'h0010, no further frames.
- With UART_TX_PARITY_EN and pe=1, send 8'h07 -> parity bit 1 before stop; without the macro -> stop follows bit 7 directly.
